// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared pipeline types and constants for the RISC-V core slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Increment counter with synchronous clear; sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] C_MAX = {W{1'b1}};

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != C_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// ============================================================================
// Module      : hazard_unit
// Description : Load-use stall, branch flush and EX operand forwarding control,
//               with shadow MEM/WB destination tracking and perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_unit
  import riscv_pkg::*;
#(
  parameter int REG_AW = riscv_pkg::REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic              RegWriteE,
  input  logic [1:0]        ResultSrcE,
  input  logic              PCSrcE,
  input  logic              perf_clr,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Shadow of the EX->MEM->WB destination pipeline; MEM and WB never stall.
  logic [REG_AW-1:0] r_rd_m;
  logic [REG_AW-1:0] r_rd_w;
  logic              r_rw_m;
  logic              r_rw_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_m <= '0;
      r_rw_m <= 1'b0;
      r_rd_w <= '0;
      r_rw_w <= 1'b0;
    end else begin
      r_rd_m <= RdE;
      r_rw_m <= RegWriteE;
      r_rd_w <= r_rd_m;
      r_rw_w <= r_rw_m;
    end
  end

  function automatic fwd_sel_t fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rd_m,
    input logic              rw_m,
    input logic [REG_AW-1:0] rd_w,
    input logic              rw_w
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (rs != '0) begin
      if (rw_m && (rd_m == rs)) begin
        sel = FWD_MEM;
      end else if (rw_w && (rd_w == rs)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

  fwd_sel_t w_fwd_a;
  fwd_sel_t w_fwd_b;
  logic     w_lw_stall;
  logic     w_stall;

  assign w_fwd_a = fwd_sel(Rs1E, r_rd_m, r_rw_m, r_rd_w, r_rw_w);
  assign w_fwd_b = fwd_sel(Rs2E, r_rd_m, r_rw_m, r_rd_w, r_rw_w);

  assign w_lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && RegWriteE && (RdE != '0)
                      && ((RdE == Rs1D) || (RdE == Rs2D));

  // A taken branch discards the dependent instruction, so it overrides the stall.
  assign w_stall = w_lw_stall && !PCSrcE;

  assign StallF    = reset && w_stall;
  assign StallD    = reset && w_stall;
  assign FlushD    = reset && PCSrcE;
  assign FlushE    = reset && (w_lw_stall || PCSrcE);
  assign ForwardAE = reset ? w_fwd_a : FWD_RF;
  assign ForwardBE = reset ? w_fwd_b : FWD_RF;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (perf_clr),
    .inc   (w_stall),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (perf_clr),
    .inc   (PCSrcE),
    .count (flush_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// ============================================================================
// Module      : tb_hazard_unit
// Description : Directed-vector scoreboard bench for hazard_unit (CNT_W = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_unit;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic             RegWriteE;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE;
  logic             perf_clr;
  logic             StallF, StallD, FlushD, FlushE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_unit #(.REG_AW(5), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RegWriteE  (RegWriteE),
    .ResultSrcE (ResultSrcE),
    .PCSrcE     (PCSrcE),
    .perf_clr   (perf_clr),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            nm;
    logic             stall;
    logic             flushd;
    logic             flushe;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input string field, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, field, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so one expectation is due every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.nm, "StallF",    {7'd0, StallF},    {7'd0, e.stall});
        chk(e.nm, "StallD",    {7'd0, StallD},    {7'd0, e.stall});
        chk(e.nm, "FlushD",    {7'd0, FlushD},    {7'd0, e.flushd});
        chk(e.nm, "FlushE",    {7'd0, FlushE},    {7'd0, e.flushe});
        chk(e.nm, "ForwardAE", {6'd0, ForwardAE}, {6'd0, e.fa});
        chk(e.nm, "ForwardBE", {6'd0, ForwardBE}, {6'd0, e.fb});
        chk(e.nm, "stall_cnt", {4'd0, stall_cnt}, {4'd0, e.sc});
        chk(e.nm, "flush_cnt", {4'd0, flush_cnt}, {4'd0, e.fc});
      end
    end
  end

  task automatic step(
    input string nm,
    input logic rst_v,
    input logic [4:0] rs1d, input logic [4:0] rs2d,
    input logic [4:0] rs1e, input logic [4:0] rs2e,
    input logic [4:0] rde,  input logic rw, input logic [1:0] rsrc,
    input logic pcs, input logic clr,
    input logic e_stall, input logic e_fd, input logic e_fe,
    input logic [1:0] e_fa, input logic [1:0] e_fb,
    input logic [CNT_W-1:0] e_sc, input logic [CNT_W-1:0] e_fc
  );
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst_v; Rs1D = rs1d; Rs2D = rs2d; Rs1E = rs1e; Rs2E = rs2e;
    RdE = rde; RegWriteE = rw; ResultSrcE = rsrc; PCSrcE = pcs; perf_clr = clr;
    e.nm = nm; e.stall = e_stall; e.flushd = e_fd; e.flushe = e_fe;
    e.fa = e_fa; e.fb = e_fb; e.sc = e_sc; e.fc = e_fc;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b0; Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0;
    RegWriteE = 1'b0; ResultSrcE = 2'b00; PCSrcE = 1'b0; perf_clr = 1'b0;

    //    name        rst rs1d rs2d rs1e rs2e rde rw rsrc  pcs clr  st fd fe fa     fb     sc fc
    step("rst_a",     0,  0,   0,   5,   0,   5,  1, 2'b00, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("rst_b",     0,  5,   0,   5,   0,   5,  1, 2'b01, 1, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("rel_shadow",1,  0,   0,   5,   5,   0,  0, 2'b00, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("add_x5",    1,  0,   0,   0,   0,   5,  1, 2'b00, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("fwd_mem_a", 1,  0,   0,   5,   0,   0,  0, 2'b00, 0, 0,  0, 0, 0, 2'b10, 2'b00, 0, 0);
    step("fwd_wb_b",  1,  0,   0,   0,   5,   0,  0, 2'b00, 0, 0,  0, 0, 0, 2'b00, 2'b01, 0, 0);
    step("fwd_gone",  1,  0,   0,   5,   5,   0,  0, 2'b00, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("add_x9_1",  1,  0,   0,   0,   0,   9,  1, 2'b00, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("add_x9_2",  1,  0,   0,   9,   0,   9,  1, 2'b00, 0, 0,  0, 0, 0, 2'b10, 2'b00, 0, 0);
    step("mem_wins",  1,  0,   0,   9,   9,   0,  0, 2'b00, 0, 0,  0, 0, 0, 2'b10, 2'b10, 0, 0);
    step("load_use",  1,  0,   7,   0,   0,   7,  1, 2'b01, 0, 0,  1, 0, 1, 2'b00, 2'b00, 0, 0);
    step("load_fwd",  1,  0,   0,   0,   7,   0,  0, 2'b00, 0, 0,  0, 0, 0, 2'b00, 2'b10, 1, 0);
    step("x0_write",  1,  0,   0,   0,   0,   0,  1, 2'b00, 0, 0,  0, 0, 0, 2'b00, 2'b00, 1, 0);
    step("x0_load",   1,  0,   0,   0,   0,   0,  1, 2'b01, 0, 0,  0, 0, 0, 2'b00, 2'b00, 1, 0);
    step("branch",    1,  0,   0,   0,   0,   0,  0, 2'b00, 1, 0,  0, 1, 1, 2'b00, 2'b00, 1, 0);
    step("post_br",   1,  0,   0,   0,   0,   0,  0, 2'b00, 0, 0,  0, 0, 0, 2'b00, 2'b00, 1, 1);
    step("br_vs_lw",  1,  3,   0,   0,   0,   3,  1, 2'b01, 1, 0,  0, 1, 1, 2'b00, 2'b00, 1, 1);
    step("post_bl",   1,  0,   0,   0,   0,   0,  0, 2'b00, 0, 0,  0, 0, 0, 2'b00, 2'b00, 1, 2);
    for (int i = 0; i < 20; i++) begin
      step("sat_run", 1,  4,   0,   0,   0,   4,  1, 2'b01, 0, 0,  1, 0, 1, 2'b00, 2'b00,
           CNT_W'((i + 1 > 15) ? 15 : i + 1), 2);
    end
    step("sat_hold",  1,  0,   0,   0,   0,   0,  0, 2'b00, 0, 0,  0, 0, 0, 2'b00, 2'b00, 15, 2);
    step("clr_stall", 1,  4,   0,   0,   0,   4,  1, 2'b01, 0, 1,  1, 0, 1, 2'b00, 2'b00, 15, 2);
    step("cleared",   1,  0,   0,   0,   0,   0,  0, 2'b00, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("br2",       1,  0,   0,   0,   0,   6,  1, 2'b00, 1, 0,  0, 1, 1, 2'b00, 2'b00, 0, 0);
    step("pre_rst",   1,  0,   0,   0,   0,   6,  1, 2'b00, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 1);
    step("async_rst", 0,  4,   0,   6,   0,   4,  1, 2'b01, 1, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("rst_shadow",1,  0,   0,   6,   6,   0,  0, 2'b00, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0);

    // Let the monitor drain, bounded.
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
